cpu_wb_bridge: RTL



---
 rtl/cpu_wb_bridge_if.sv | 24 ++
 rtl/cpu_wb_bridge.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cpu_wb_bridge_if.sv
// Wishbone B3 classic master-side bus bundle between a cpu_wb_bridge and the interconnect.
// Signal names follow the bridge's view: _o leaves the bridge, _i enters it.
interface cpu_wb_bridge_if;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;

  modport master (
    input  wishbone_data_i, wishbone_ack_i,
    output wishbone_addr_o, wishbone_data_o, wishbone_we_o,
           wishbone_sel_o, wishbone_stb_o, wishbone_cyc_o
  );

  modport slave (
    output wishbone_data_i, wishbone_ack_i,
    input  wishbone_addr_o, wishbone_data_o, wishbone_we_o,
           wishbone_sel_o, wishbone_stb_o, wishbone_cyc_o
  );
endinterface

// File: rtl/cpu_wb_bridge.sv
// OpenMIPS memory port to Wishbone classic master bridge (IDLE/BUSY/WAIT_FOR_STALL).
// Optional BUSY timeout abort is built when CPU_WB_TIMEOUT_EN is defined.
module cpu_wb_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  cpu_wb_bridge_if.master wb
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("cpu_wb_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_t;

  state_t      state;
  logic [31:0] rd_buf;
  logic        stalled;
  logic        ack_ok;
  logic        tmo_hit;

  assign stalled = |stall_i;
  // Flush beats ack: an acked transfer in a flushed cycle is simply dropped.
  assign ack_ok  = (state == BUSY) && wb.wishbone_ack_i && !flush_i;

`ifdef CPU_WB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  assign tmo_hit = (state == BUSY) && !flush_i && !wb.wishbone_ack_i &&
                   (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      rd_buf             <= '0;
      wb.wishbone_cyc_o  <= 1'b0;
      wb.wishbone_stb_o  <= 1'b0;
      wb.wishbone_we_o   <= 1'b0;
      wb.wishbone_sel_o  <= '0;
      wb.wishbone_addr_o <= '0;
      wb.wishbone_data_o <= '0;
`ifdef CPU_WB_TIMEOUT_EN
      tmo_cnt            <= '0;
      bus_err_o          <= 1'b0;
`endif
    end else begin
`ifdef CPU_WB_TIMEOUT_EN
      bus_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef CPU_WB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (cpu_ce_i && !flush_i) begin
            wb.wishbone_cyc_o  <= 1'b1;
            wb.wishbone_stb_o  <= 1'b1;
            wb.wishbone_we_o   <= cpu_we_i;
            wb.wishbone_sel_o  <= cpu_sel_i;
            wb.wishbone_addr_o <= cpu_addr_i;
            wb.wishbone_data_o <= cpu_data_i;
            state              <= BUSY;
          end
        end

        BUSY: begin
          if (flush_i || wb.wishbone_ack_i || tmo_hit) begin
            wb.wishbone_cyc_o  <= 1'b0;
            wb.wishbone_stb_o  <= 1'b0;
            wb.wishbone_we_o   <= 1'b0;
            wb.wishbone_sel_o  <= '0;
            wb.wishbone_addr_o <= '0;
            wb.wishbone_data_o <= '0;
`ifdef CPU_WB_TIMEOUT_EN
            tmo_cnt            <= '0;
`endif
            if (flush_i) begin
              rd_buf <= '0;
              state  <= IDLE;
            end else begin
              // Aborted reads hand zero to the pipeline.
              rd_buf <= wb.wishbone_ack_i ? wb.wishbone_data_i : 32'h0;
              state  <= stalled ? WAIT_FOR_STALL : IDLE;
`ifdef CPU_WB_TIMEOUT_EN
              bus_err_o <= !wb.wishbone_ack_i;
`endif
            end
          end else begin
`ifdef CPU_WB_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end

        WAIT_FOR_STALL: begin
          if (flush_i) begin
            rd_buf <= '0;
            state  <= IDLE;
          end else if (!stalled) begin
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (state)
      IDLE: stallreq_o = cpu_ce_i && !flush_i;
      BUSY: begin
        if (ack_ok)       cpu_data_o = cpu_we_i ? 32'h0 : wb.wishbone_data_i;
        else if (!tmo_hit) stallreq_o = 1'b1;
      end
      WAIT_FOR_STALL: cpu_data_o = rd_buf;
      default: ;
    endcase
  end

endmodule
